// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline hazard/sequencing controller:
// stage p_ctrl encodings and the controller FSM state type.
package pipeline_ctrl_pkg;

    // p_ctrl: bit0 = hold (dominates), bit1 = load bubble
    localparam logic [1:0] P_RUN   = 2'b00;
    localparam logic [1:0] P_STALL = 2'b01;
    localparam logic [1:0] P_FLUSH = 2'b10;

    typedef enum logic {
        PC_RUN     = 1'b0,
        PC_MC_BUSY = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard detection: the ID instruction reads a register that the
// load currently in EX has not yet produced. x0 never creates a hazard.
module pipeline_ctrl_load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       hazard
);

    assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard/sequencing controller for the 5-stage pipeline.
// Produces the per-stage p_ctrl and PC hold, tracks multi-cycle EX ops and
// keeps stall/redirect performance counters.
//
// state      | meaning
// -----------+------------------------------------------------------------
// PC_RUN     | normal issue; resolves MC start, redirect and load-use
// PC_MC_BUSY | multi-cycle op occupies EX; cnt counts remaining stalls,
//            | cnt==0 is the release cycle
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             ex_mc_start,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic [1:0]       if_id_ctrl,
    output logic [1:0]       id_ex_ctrl,
    output logic [1:0]       ex_mem_ctrl,
    output logic [1:0]       mem_wb_ctrl,
    output logic             mc_busy,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // cnt only ever holds MC_LATENCY-2 down to 0
    localparam int CW = (MC_LATENCY > 2) ? $clog2(MC_LATENCY - 1) : 1;
    localparam logic [CW-1:0] MC_LOAD = CW'(MC_LATENCY - 2);

    pc_state_t   state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic        mem_wait;
    logic        load_use;
    logic        flush_hit;

    assign mem_wait = mem_req && !mem_ready;
    assign mc_busy  = (state == PC_MC_BUSY);

    pipeline_ctrl_load_use_detect u_load_use (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .hazard      (load_use)
    );

    // State and occupancy counter register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= PC_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Priority mux: reset, then memory wait, then FSM-specific hazards
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        flush_hit   = 1'b0;
        pc_stall    = 1'b0;
        if_id_ctrl  = P_RUN;
        id_ex_ctrl  = P_RUN;
        ex_mem_ctrl = P_RUN;
        mem_wb_ctrl = P_RUN;
        if (reset) begin
            pc_stall    = 1'b1;
            if_id_ctrl  = P_FLUSH;
            id_ex_ctrl  = P_FLUSH;
            ex_mem_ctrl = P_FLUSH;
            mem_wb_ctrl = P_FLUSH;
        end else if (mem_wait) begin
            pc_stall    = 1'b1;
            if_id_ctrl  = P_STALL;
            id_ex_ctrl  = P_STALL;
            ex_mem_ctrl = P_STALL;
            mem_wb_ctrl = P_FLUSH;
        end else begin
            case (state)
                PC_RUN: begin
                    if (ex_mc_start) begin
                        pc_stall    = 1'b1;
                        if_id_ctrl  = P_STALL;
                        id_ex_ctrl  = P_STALL;
                        ex_mem_ctrl = P_FLUSH;
                        cnt_nx      = MC_LOAD;
                        state_nx    = PC_MC_BUSY;
                    end else if (ex_redirect) begin
                        if_id_ctrl  = P_FLUSH;
                        id_ex_ctrl  = P_FLUSH;
                        flush_hit   = 1'b1;
                    end else if (load_use) begin
                        pc_stall    = 1'b1;
                        if_id_ctrl  = P_STALL;
                        id_ex_ctrl  = P_FLUSH;
                    end
                end
                PC_MC_BUSY: begin
                    if (cnt != '0) begin
                        pc_stall    = 1'b1;
                        if_id_ctrl  = P_STALL;
                        id_ex_ctrl  = P_STALL;
                        ex_mem_ctrl = P_FLUSH;
                        cnt_nx      = cnt - CW'(1);
                    end else begin
                        state_nx    = PC_RUN;
                    end
                end
                default: state_nx = PC_RUN;
            endcase
        end
    end

    // Performance counters; wrap naturally at 2^CNT_W
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (pc_stall) stall_count <= stall_count + CNT_W'(1);
            if (flush_hit) flush_count <= flush_count + CNT_W'(1);
        end
    end

    // A multi-cycle op and a taken redirect cannot share EX
    mc_redirect_excl: assert property (@(posedge clock) disable iff (reset)
        !(ex_mc_start && ex_redirect));

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the driver applies directed vectors
// and queues the hand-computed response; a monitor compares on negedge.
module tb_pipeline_ctrl;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] S = 2'b01;
    localparam logic [1:0] F = 2'b10;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       redir;
        logic       mc;
        logic       mq;
        logic       my;
    } stim_t;

    typedef struct {
        logic        pc;
        logic [1:0]  ifid;
        logic [1:0]  idex;
        logic [1:0]  exmem;
        logic [1:0]  memwb;
        logic        busy;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, ex_mc_start;
    logic        mem_req, mem_ready;
    logic        pc_stall, mc_busy;
    logic [1:0]  if_id_ctrl, id_ex_ctrl, ex_mem_ctrl, mem_wb_ctrl;
    logic [31:0] stall_count, flush_count;

    exp_t        sb[$];
    logic [31:0] m_sc, m_fc;
    int          checks;
    int          errors;

    pipeline_ctrl #(.MC_LATENCY(4), .CNT_W(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .ex_redirect (ex_redirect),
        .ex_mc_start (ex_mc_start),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .pc_stall    (pc_stall),
        .if_id_ctrl  (if_id_ctrl),
        .id_ex_ctrl  (id_ex_ctrl),
        .ex_mem_ctrl (ex_mem_ctrl),
        .mem_wb_ctrl (mem_wb_ctrl),
        .mc_busy     (mc_busy),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic stim_t st(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic mr, input logic redir, input logic mc,
                                 input logic mq, input logic my);
        stim_t s;
        s.rst = r; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.rd = rd;
        s.mr = mr; s.redir = redir; s.mc = mc; s.mq = mq; s.my = my;
        return s;
    endfunction

    // Apply one cycle of stimulus #1 after posedge and queue its expected response.
    // Counter expectations are what the DUT shows during this cycle, i.e. before
    // this cycle's stall/redirect is counted.
    task automatic drive(input stim_t s, input logic pc, input logic [1:0] a,
                         input logic [1:0] b, input logic [1:0] c, input logic [1:0] d,
                         input logic busy);
        exp_t e;
        @(posedge clock);
        #1;
        reset = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2; id_uses_rs1 = s.u1;
        id_uses_rs2 = s.u2; ex_rd = s.rd; ex_mem_read = s.mr; ex_redirect = s.redir;
        ex_mc_start = s.mc; mem_req = s.mq; mem_ready = s.my;
        if (s.rst) begin
            m_sc = '0;
            m_fc = '0;
        end
        e.pc = pc; e.ifid = a; e.idex = b; e.exmem = c; e.memwb = d; e.busy = busy;
        e.sc = m_sc; e.fc = m_fc;
        sb.push_back(e);
        if (!s.rst) begin
            if (pc) m_sc = m_sc + 32'd1;
            if (a == F && !pc) m_fc = m_fc + 32'd1;
        end
    endtask

    // Monitor: pop one expectation per cycle and compare
    always @(negedge clock) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks = checks + 1;
            if ({pc_stall, if_id_ctrl, id_ex_ctrl, ex_mem_ctrl, mem_wb_ctrl, mc_busy} !==
                {e.pc, e.ifid, e.idex, e.exmem, e.memwb, e.busy}) begin
                errors = errors + 1;
                $display("FAIL ctrl t=%0t got pc=%b if=%b id=%b ex=%b mw=%b busy=%b want pc=%b if=%b id=%b ex=%b mw=%b busy=%b",
                         $time, pc_stall, if_id_ctrl, id_ex_ctrl, ex_mem_ctrl, mem_wb_ctrl, mc_busy,
                         e.pc, e.ifid, e.idex, e.exmem, e.memwb, e.busy);
            end
            checks = checks + 1;
            if (stall_count !== e.sc || flush_count !== e.fc) begin
                errors = errors + 1;
                $display("FAIL counters t=%0t got stall=%0d flush=%0d want stall=%0d flush=%0d",
                         $time, stall_count, flush_count, e.sc, e.fc);
            end
        end
    end

    initial begin
        stim_t idle;
        checks = 0; errors = 0; m_sc = '0; m_fc = '0;
        reset = 1'b1; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd = '0; ex_mem_read = 1'b0; ex_redirect = 1'b0; ex_mc_start = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
        idle = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state, then idle release
        drive(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, F, F, F, F, 0);
        drive(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, F, F, F, F, 0);
        drive(idle, 0, R, R, R, R, 0);
        drive(idle, 0, R, R, R, R, 0);

        // Load-use through rs2, single bubble, then clean
        drive(st(0, 3, 5, 1, 1, 5, 1, 0, 0, 0, 0), 1, S, F, R, R, 0);
        drive(idle, 0, R, R, R, R, 0);
        // Load-use through rs1
        drive(st(0, 7, 8, 1, 0, 7, 1, 0, 0, 0, 0), 1, S, F, R, R, 0);
        // rs1 matches but is not read
        drive(st(0, 7, 8, 0, 1, 7, 1, 0, 0, 0, 0), 0, R, R, R, R, 0);
        // rd = x0 never hazards
        drive(st(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0), 0, R, R, R, R, 0);
        // match but EX is not a load
        drive(st(0, 5, 5, 1, 1, 5, 0, 0, 0, 0, 0), 0, R, R, R, R, 0);
        // Redirect beats load-use
        drive(st(0, 3, 5, 1, 1, 5, 1, 1, 0, 0, 0), 0, F, F, R, R, 0);
        drive(idle, 0, R, R, R, R, 0);

        // Multi-cycle op, MC_LATENCY=4: three stall cycles then release
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, S, S, F, R, 0);
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, S, S, F, R, 1);
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, S, S, F, R, 1);
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0, R, R, R, R, 1);
        drive(idle, 0, R, R, R, R, 0);

        // Multi-cycle op with 3 memory wait cycles in its 2nd cycle: 7 cycles in EX
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, S, S, F, R, 0);
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), 1, S, S, S, F, 1);
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), 1, S, S, S, F, 1);
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), 1, S, S, S, F, 1);
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), 1, S, S, F, R, 1);
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, S, S, F, R, 1);
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0, R, R, R, R, 1);
        drive(idle, 0, R, R, R, R, 0);

        // Memory wait masks a redirect; redirect acts once memory is ready
        drive(st(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), 1, S, S, S, F, 0);
        drive(st(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1), 0, F, F, R, R, 0);
        drive(idle, 0, R, R, R, R, 0);

        // Reset in the middle of MC_BUSY aborts the op and clears counters
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, S, S, F, R, 0);
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, S, S, F, R, 1);
        drive(st(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, F, F, F, F, 0);
        drive(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, F, F, F, F, 0);
        drive(idle, 0, R, R, R, R, 0);
        drive(idle, 0, R, R, R, R, 0);

        @(negedge clock);
        #1;
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
